wb_macro_sched: RTL and testbench

Wishbone slave-side scheduler between the Caravel management Wishbone port and up to NUM_SLV user macros inside `user_project_wrapper`. It decodes each transaction to one macro window or a local CSR bank, forwards it, and returns exactly one `wbs_ack_o` per transaction. Unmapped, disabled or hung macros get a bounded error response instead of stalling the management core. Timeout events are counted and raised as an interrupt.

---
 rtl/wb_macro_sched.sv | 215 +++++++++++++++++++++
 tb/tb_wb_macro_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_macro_sched.sv
// Wishbone scheduler between the Caravel management port and NUM_SLV user macros plus a
// local CSR bank; every transaction ends in exactly one ack, hung or missing targets get an error word.
module wb_macro_sched #(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [3:0]              wbs_sel_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_SLV-1:0]      m_cyc_o,
  output logic [NUM_SLV-1:0]      m_stb_o,
  output logic                    m_we_o,
  output logic [31:0]             m_adr_o,
  output logic [31:0]             m_dat_o,
  output logic [3:0]              m_sel_o,
  input  logic [NUM_SLV-1:0]      m_ack_i,
  input  logic [32*NUM_SLV-1:0]   m_dat_i,
  output logic                    irq_o
);

  localparam logic [7:0]  TO_LAST      = 8'(TIMEOUT - 1);
  localparam logic [31:0] ID_WORD      = 32'h5743_4844;
  localparam logic [31:0] ERR_UNMAPPED = 32'hBADD_0001;
  localparam logic [31:0] ERR_DISABLED = 32'hBADD_0002;
  localparam logic [31:0] ERR_TIMEOUT  = 32'hBADD_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [3:0]           idx_r;
  logic [7:0]           timer_r;
  logic [NUM_SLV-1:0]   en_r;
  logic [7:0]           tocnt_r;
  logic [31:0]          erradr_r;
  logic [31:0]          resp_dat_r;
  logic                 irq_r;
  logic                 m_we_r;
  logic [31:0]          m_adr_r;
  logic [31:0]          m_dat_r;
  logic [3:0]           m_sel_r;

  logic                 req_s;
  logic                 hit_s;
  logic [3:0]           adr_idx_s;
  logic                 is_csr_s;
  logic                 is_mac_s;
  logic                 mac_en_s;
  logic                 ack_sel_s;
  logic [31:0]          dat_sel_s;
  logic [NUM_SLV-1:0]   stb_onehot_s;
  logic                 timeout_s;
  logic [31:0]          csr_rd_s;

  // Decode the incoming request against the macro windows and the CSR window.
  always_comb begin
    req_s     = wbs_cyc_i & wbs_stb_i;
    hit_s     = (wbs_adr_i[31:20] == BASE_ADDR[31:20]);
    adr_idx_s = wbs_adr_i[19:16];
    is_csr_s  = hit_s && (adr_idx_s == 4'hF);
    is_mac_s  = 1'b0;
    mac_en_s  = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      is_mac_s = is_mac_s | (hit_s && (adr_idx_s == 4'(k)));
      mac_en_s = mac_en_s | (hit_s && (adr_idx_s == 4'(k)) && en_r[k]);
    end
  end

  // Only the latched macro's ack and data are visible; everything else is ignored.
  always_comb begin
    ack_sel_s    = 1'b0;
    dat_sel_s    = 32'd0;
    stb_onehot_s = {NUM_SLV{1'b0}};
    for (int k = 0; k < NUM_SLV; k++) begin
      stb_onehot_s[k] = (idx_r == 4'(k));
      ack_sel_s       = ack_sel_s | ((idx_r == 4'(k)) & m_ack_i[k]);
      dat_sel_s       = dat_sel_s | ({32{idx_r == 4'(k)}} & m_dat_i[32*k +: 32]);
    end
    timeout_s = (timer_r == TO_LAST);
  end

  // CSR read mux, sampled in IDLE so the response reflects the pre-write value.
  always_comb begin
    csr_rd_s = 32'd0;
    case (wbs_adr_i[3:2])
      2'd0:    csr_rd_s[NUM_SLV-1:0] = en_r;
      2'd1:    csr_rd_s = {24'd0, tocnt_r};
      2'd2:    csr_rd_s = erradr_r;
      2'd3:    csr_rd_s = ID_WORD;
      default: csr_rd_s = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a macro ack beats both the timeout and a master abort.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (is_mac_s && mac_en_s) state_s = ST_BUSY;
          else                      state_s = ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack_sel_s || timeout_s) state_s = ST_RESP;
        else if (!wbs_cyc_i)        state_s = ST_IDLE;
        else                        state_s = ST_BUSY;
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they drop with the async reset.
  always_comb begin
    wbs_ack_o = (state_r == ST_RESP);
    wbs_dat_o = (state_r == ST_RESP) ? resp_dat_r : 32'd0;
    m_cyc_o   = (state_r == ST_BUSY) ? stb_onehot_s : {NUM_SLV{1'b0}};
    m_stb_o   = (state_r == ST_BUSY) ? stb_onehot_s : {NUM_SLV{1'b0}};
    m_we_o    = m_we_r;
    m_adr_o   = m_adr_r;
    m_dat_o   = m_dat_r;
    m_sel_o   = m_sel_r;
    irq_o     = irq_r;
  end

  // Transaction latch, CSR bank, timeout timer and error bookkeeping.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      idx_r      <= 4'd0;
      timer_r    <= 8'd0;
      en_r       <= {NUM_SLV{1'b1}};
      tocnt_r    <= 8'd0;
      erradr_r   <= 32'd0;
      resp_dat_r <= 32'd0;
      irq_r      <= 1'b0;
      m_we_r     <= 1'b0;
      m_adr_r    <= 32'd0;
      m_dat_r    <= 32'd0;
      m_sel_r    <= 4'd0;
    end else begin
      irq_r <= (tocnt_r != 8'd0);
      case (state_r)
        ST_IDLE: begin
          timer_r <= 8'd0;
          if (req_s) begin
            idx_r   <= adr_idx_s;
            m_we_r  <= wbs_we_i;
            m_adr_r <= wbs_adr_i;
            m_dat_r <= wbs_dat_i;
            m_sel_r <= wbs_sel_i;
            if (is_csr_s) begin
              resp_dat_r <= csr_rd_s;
              if (wbs_we_i && (wbs_adr_i[3:2] == 2'd0) && wbs_sel_i[0]) begin
                en_r <= wbs_dat_i[NUM_SLV-1:0];
              end else if (wbs_we_i && (wbs_adr_i[3:2] == 2'd1)) begin
                tocnt_r <= 8'd0;
              end else begin
                en_r <= en_r;
              end
            end else if (!is_mac_s) begin
              resp_dat_r <= ERR_UNMAPPED;
              erradr_r   <= wbs_adr_i;
            end else if (!mac_en_s) begin
              resp_dat_r <= ERR_DISABLED;
              erradr_r   <= wbs_adr_i;
            end else begin
              resp_dat_r <= resp_dat_r;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        ST_BUSY: begin
          timer_r <= timer_r + 8'd1;
          if (ack_sel_s) begin
            resp_dat_r <= dat_sel_s;
          end else if (timeout_s) begin
            resp_dat_r <= ERR_TIMEOUT;
            erradr_r   <= m_adr_r;
            if (tocnt_r != 8'hFF) tocnt_r <= tocnt_r + 8'd1;
            else                  tocnt_r <= tocnt_r;
          end else begin
            resp_dat_r <= resp_dat_r;
          end
        end
        default: timer_r <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_macro_sched.sv
// Self-checking bench for wb_macro_sched: directed table, multi-cycle corner sequences,
// then randomized transactions scored against a transaction-level reference model.
module tb_wb_macro_sched;

  localparam int NS = 4;
  localparam int TO = 255;

  logic            wb_clk_i  = 1'b0;
  logic            wb_rst_ni = 1'b0;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_we_i  = 1'b0;
  logic [31:0]     wbs_adr_i = 32'd0;
  logic [31:0]     wbs_dat_i = 32'd0;
  logic [3:0]      wbs_sel_i = 4'd0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [NS-1:0]   m_cyc_o;
  logic [NS-1:0]   m_stb_o;
  logic            m_we_o;
  logic [31:0]     m_adr_o;
  logic [31:0]     m_dat_o;
  logic [3:0]      m_sel_o;
  logic [NS-1:0]   m_ack_i;
  logic [32*NS-1:0] m_dat_i;
  logic            irq_o;

  wb_macro_sched #(.NUM_SLV(NS), .BASE_ADDR(32'h3000_0000), .TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
    .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Macro responders: macro k acks mac_delay[k] cycles after its strobe rises.
  logic [NS-1:0] resp_ack  = 4'd0;
  logic [NS-1:0] extra_ack = 4'd0;
  logic [31:0]   mac_data [NS];
  int            mac_delay[NS];
  logic          mac_hang [NS];
  int            stb_cnt  [NS];

  assign m_ack_i = resp_ack | extra_ack;
  always_comb begin
    for (int k = 0; k < NS; k++) m_dat_i[32*k +: 32] = mac_data[k];
  end

  always @(negedge wb_clk_i) begin
    for (int k = 0; k < NS; k++) begin
      stb_cnt[k]  <= m_stb_o[k] ? stb_cnt[k] + 1 : 0;
      resp_ack[k] <= m_stb_o[k] && !mac_hang[k] && ((stb_cnt[k] + 1) == mac_delay[k] + 1);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, what, act, exp);
    end
  endtask

  // One full transaction from a negedge; checks latency, data, strobes, forwarded fields, single ack, irq.
  task automatic do_txn(input string nm, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int exp_lat, input logic [31:0] exp_dat,
                        input int exp_stb, input logic exp_irq);
    int lat;
    logic got;
    logic fwd_ok;
    logic [31:0] rd;
    logic [3:0] stb_seen;
    logic [3:0] exp_mask;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0; got = 1'b0; fwd_ok = 1'b1; rd = 32'd0; stb_seen = 4'd0;
    while (!got && lat < 400) begin
      @(negedge wb_clk_i);
      lat++;
      stb_seen = stb_seen | m_stb_o;
      if (m_cyc_o != m_stb_o) fwd_ok = 1'b0;
      if (m_stb_o != 4'd0 && (m_adr_o != adr || m_we_o != we || m_dat_o != dat || m_sel_o != sel)) fwd_ok = 1'b0;
      if (wbs_ack_o) begin
        got = 1'b1;
        rd  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    exp_mask = (exp_stb < 0) ? 4'd0 : (4'd1 << exp_stb);
    chk(nm, "latency", 32'(lat), 32'(exp_lat));
    if (!we) chk(nm, "rdata", rd, exp_dat);
    chk(nm, "strobes", {28'd0, stb_seen}, {28'd0, exp_mask});
    chk(nm, "fwd", {31'd0, fwd_ok}, 32'd1);
    @(negedge wb_clk_i);
    chk(nm, "single_ack", {wbs_ack_o, wbs_dat_o[30:0]}, 32'd0);
    chk(nm, "irq", {31'd0, irq_o}, {31'd0, exp_irq});
  endtask

  // Reference model state: CSR contents as seen from the bus.
  logic [3:0]  md_en;
  logic [7:0]  md_tocnt;
  logic [31:0] md_erradr;

  task automatic model_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel,
                           output int lat, output logic [31:0] rd, output int stb);
    logic hit;
    int   idx;
    hit = (adr[31:20] == 12'h300);
    idx = int'(adr[19:16]);
    stb = -1;
    lat = 1;
    if (hit && idx == 15) begin
      case (adr[3:2])
        2'd0:    rd = {28'd0, md_en};
        2'd1:    rd = {24'd0, md_tocnt};
        2'd2:    rd = md_erradr;
        default: rd = 32'h5743_4844;
      endcase
      if (we && adr[3:2] == 2'd0 && sel[0]) md_en = dat[3:0];
      if (we && adr[3:2] == 2'd1) md_tocnt = 8'd0;
    end else if (hit && idx < NS) begin
      if (!md_en[idx]) begin
        rd = 32'hBADD_0002;
        md_erradr = adr;
      end else begin
        stb = idx;
        if (mac_hang[idx] || mac_delay[idx] > TO - 1) begin
          lat = TO + 1;
          rd  = 32'hBADD_0003;
          md_erradr = adr;
          if (md_tocnt != 8'd255) md_tocnt = md_tocnt + 8'd1;
        end else begin
          lat = mac_delay[idx] + 2;
          rd  = mac_data[idx];
        end
      end
    end else begin
      rd = 32'hBADD_0001;
      md_erradr = adr;
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdat;
    int          stb;
    logic        irq;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int          e_lat;
    int          e_stb;
    logic [31:0] e_dat;
    logic [31:0] adr;
    logic [3:0]  idx;
    logic [11:0] top;
    logic        flag;

    tbl[0]  = '{32'h300F_0000, 1'b0, 32'h0,  4'hF, 1,      32'h0000_000F, -1, 1'b0};
    tbl[1]  = '{32'h300F_000C, 1'b0, 32'h0,  4'hF, 1,      32'h5743_4844, -1, 1'b0};
    tbl[2]  = '{32'h3001_0010, 1'b1, 32'hA5, 4'hF, 5,      32'h0,          1, 1'b0};
    tbl[3]  = '{32'h3000_0004, 1'b0, 32'h0,  4'hF, 2,      32'h1234_5678,  0, 1'b0};
    tbl[4]  = '{32'h3002_0000, 1'b0, 32'h0,  4'hF, TO + 1, 32'hBADD_0003,  2, 1'b1};
    tbl[5]  = '{32'h300F_0004, 1'b0, 32'h0,  4'hF, 1,      32'h0000_0001, -1, 1'b1};
    tbl[6]  = '{32'h300F_0008, 1'b0, 32'h0,  4'hF, 1,      32'h3002_0000, -1, 1'b1};
    tbl[7]  = '{32'h300F_0004, 1'b1, 32'h0,  4'hF, 1,      32'h0,         -1, 1'b0};
    tbl[8]  = '{32'h300F_0004, 1'b0, 32'h0,  4'hF, 1,      32'h0000_0000, -1, 1'b0};
    tbl[9]  = '{32'h300F_0000, 1'b1, 32'hB,  4'h1, 1,      32'h0,         -1, 1'b0};
    tbl[10] = '{32'h3002_0000, 1'b0, 32'h0,  4'hF, 1,      32'hBADD_0002, -1, 1'b0};
    tbl[11] = '{32'h3005_0000, 1'b0, 32'h0,  4'hF, 1,      32'hBADD_0001, -1, 1'b0};
    tbl[12] = '{32'h300F_0008, 1'b0, 32'h0,  4'hF, 1,      32'h3005_0000, -1, 1'b0};
    tbl[13] = '{32'h300F_0000, 1'b0, 32'h0,  4'hF, 1,      32'h0000_000B, -1, 1'b0};
    tbl[14] = '{32'h300F_0000, 1'b1, 32'h0,  4'hE, 1,      32'h0,         -1, 1'b0};
    tbl[15] = '{32'h300F_0000, 1'b0, 32'h0,  4'hF, 1,      32'h0000_000B, -1, 1'b0};
    tbl[16] = '{32'h3100_0000, 1'b0, 32'h0,  4'hF, 1,      32'hBADD_0001, -1, 1'b0};
    tbl[17] = '{32'h300F_0000, 1'b1, 32'hF,  4'h1, 1,      32'h0,         -1, 1'b0};
    tbl[18] = '{32'h3003_0000, 1'b0, 32'h0,  4'hF, 3,      32'h0BAD_F00D,  3, 1'b0};

    mac_data[0] = 32'h1234_5678; mac_delay[0] = 0; mac_hang[0] = 1'b0;
    mac_data[1] = 32'hCAFE_0001; mac_delay[1] = 3; mac_hang[1] = 1'b0;
    mac_data[2] = 32'h2222_2222; mac_delay[2] = 0; mac_hang[2] = 1'b1;
    mac_data[3] = 32'h0BAD_F00D; mac_delay[3] = 1; mac_hang[3] = 1'b0;
    for (int k = 0; k < NS; k++) stb_cnt[k] = 0;

    repeat (3) @(negedge wb_clk_i);
    chk("reset", "ack_dat", {wbs_ack_o, wbs_dat_o[30:0]}, 32'd0);
    chk("reset", "strobes", {24'd0, m_cyc_o, m_stb_o}, 32'd0);
    chk("reset", "m_fields", m_adr_o | m_dat_o | {27'd0, m_we_o, m_sel_o}, 32'd0);
    chk("reset", "irq", {31'd0, irq_o}, 32'd0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);

    for (int i = 0; i < 19; i++) begin
      do_txn($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel,
             tbl[i].lat, tbl[i].rdat, tbl[i].stb, tbl[i].irq);
    end

    // Ack from a non-selected macro during the transaction is ignored.
    extra_ack = 4'b0010;
    do_txn("spurious_ack", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 2, 32'h1234_5678, 0, 1'b0);
    extra_ack = 4'b0000;

    // Ack on the last allowed BUSY cycle wins over the timeout.
    mac_hang[2] = 1'b0; mac_delay[2] = TO - 1;
    do_txn("ack_at_limit", 32'h3002_0000, 1'b0, 32'h0, 4'hF, TO + 1, 32'h2222_2222, 2, 1'b0);
    do_txn("tocnt_after_limit", 32'h300F_0004, 1'b0, 32'h0, 4'hF, 1, 32'h0, -1, 1'b0);
    mac_delay[2] = TO;
    do_txn("ack_too_late", 32'h3002_0000, 1'b0, 32'h0, 4'hF, TO + 1, 32'hBADD_0003, 2, 1'b1);
    do_txn("tocnt_clear", 32'h300F_0004, 1'b1, 32'h0, 4'h0, 1, 32'h0, -1, 1'b0);

    // Master abort during BUSY: strobes drop, no ack, nothing counted.
    mac_hang[2] = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3002_0000; wbs_sel_i = 4'hF;
    repeat (5) @(negedge wb_clk_i);
    chk("abort", "stb_before", {28'd0, m_stb_o}, 32'h4);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    flag = 1'b0;
    repeat (4) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || m_stb_o != 4'd0) flag = 1'b1;
    end
    chk("abort", "quiet_after", {31'd0, flag}, 32'd0);
    do_txn("abort_tocnt", 32'h300F_0004, 1'b0, 32'h0, 4'hF, 1, 32'h0, -1, 1'b0);

    // Macro ack in the same cycle as a master abort still produces the response.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3003_0000;
    repeat (2) @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    chk("ack_abort", "ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("ack_abort", "rdata", wbs_dat_o, 32'h0BAD_F00D);
    @(negedge wb_clk_i);
    chk("ack_abort", "ack_drop", {31'd0, wbs_ack_o}, 32'd0);

    // Reset while BUSY: strobes drop at once, CSRs return to reset values.
    do_txn("en_0111", 32'h300F_0000, 1'b1, 32'h7, 4'h1, 1, 32'h0, -1, 1'b0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3002_0000;
    repeat (10) @(negedge wb_clk_i);
    chk("rst_busy", "stb_before", {28'd0, m_stb_o}, 32'h4);
    wb_rst_ni = 1'b0;
    #1;
    chk("rst_busy", "stb_now", {24'd0, m_cyc_o, m_stb_o}, 32'd0);
    chk("rst_busy", "ack_now", {31'd0, wbs_ack_o}, 32'd0);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    do_txn("rst_en", 32'h300F_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0000_000F, -1, 1'b0);
    do_txn("rst_erradr", 32'h300F_0008, 1'b0, 32'h0, 4'hF, 1, 32'h0, -1, 1'b0);
    mac_hang[2] = 1'b0; mac_delay[2] = 2;
    do_txn("rst_next", 32'h3002_0004, 1'b0, 32'h0, 4'hF, 4, 32'h2222_2222, 2, 1'b0);

    // Randomized traffic against the reference model.
    md_en = 4'hF; md_tocnt = 8'd0; md_erradr = 32'd0;
    for (int n = 0; n < 80; n++) begin
      int pick;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
      for (int k = 0; k < NS; k++) begin
        mac_delay[k] = $urandom_range(0, 5);
        mac_data[k]  = $urandom;
        mac_hang[k]  = ($urandom_range(0, 19) == 0);
      end
      pick = $urandom_range(0, 9);
      if (pick <= 4)      idx = 4'($urandom_range(0, 3));
      else if (pick == 7) idx = 4'($urandom_range(4, 14));
      else                idx = 4'hF;
      top = 12'h300;
      if (pick == 8) begin
        top = 12'($urandom);
        if (top == 12'h300) top = 12'h7FF;
      end
      adr = {top, idx, 16'($urandom)};
      we  = 1'($urandom);
      dat = $urandom;
      sel = 4'($urandom);
      extra_ack = 4'($urandom);
      if (top == 12'h300 && idx < 4'(NS)) extra_ack[idx[1:0]] = 1'b0;
      model_txn(adr, we, dat, sel, e_lat, e_dat, e_stb);
      do_txn($sformatf("rnd%0d", n), adr, we, dat, sel, e_lat, e_dat, e_stb, md_tocnt != 8'd0);
      extra_ack = 4'b0000;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
